mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing the MCU internal-memory AXI4-Lite slave port between N_REQ
//  requesters: instruction fetch, data load/store and UART DMA.
//  Each requester drives a simple hold-until-done request port. The arbiter runs one
//  transaction at a time on the AXI4-Lite master side and returns a 1-cycle completion pulse.
// PARAMETERS
//  N_REQ          2           number of requesters (>=2); index 0 = instruction fetch
//  AXI_AWIDTH     32          address width
//  AXI_DWIDTH     32          data width; WSTRB width = AXI_DWIDTH/8
//  INT_MEM_SIZE   65536*8     bytes of internal memory; used only by the range check
// PORTS
//  CLK           in   1                system clock, rising edge
//  NRST          in   1                asynchronous active-low reset
//  REQ_VALID     in   N_REQ            per-requester request, held until its DONE
//  REQ_WE        in   N_REQ            1 = write, 0 = read
//  REQ_ADDR      in   N_REQ*AWIDTH     byte addresses, requester i at [i*AWIDTH +: AWIDTH]
//  REQ_WDATA     in   N_REQ*DWIDTH     write data, packed as REQ_ADDR
//  REQ_WSTRB     in   N_REQ*DWIDTH/8   byte strobes, packed as REQ_ADDR
//  REQ_DONE      out  N_REQ            1-cycle completion pulse, one-hot or zero
//  REQ_RDATA     out  DWIDTH           read data, valid while any REQ_DONE bit is high
//  REQ_ERR       out  1                error flag, valid while any REQ_DONE bit is high
//  M_AWADDR/M_AWVALID out, M_AWREADY in      AXI-Lite AW channel
//  M_WDATA/M_WSTRB/M_WVALID out, M_WREADY in AXI-Lite W channel
//  M_BRESP[1:0]/M_BVALID in, M_BREADY out    AXI-Lite B channel
//  M_ARADDR/M_ARVALID out, M_ARREADY in      AXI-Lite AR channel
//  M_RDATA/M_RRESP[1:0]/M_RVALID in, M_RREADY out  AXI-Lite R channel
// BEHAVIOUR
//  - Reset (NRST low, async): state IDLE, priority pointer 0, every VALID/READY/DONE/ERR
//    output 0, REQ_RDATA 0, all M_* address/data outputs 0.
//  - FSM states: IDLE, AR, R, AWW, B, RSP.
//  - IDLE: pick the first set REQ_VALID bit at or after the pointer (wrapping). Latch the
//    grant index, WE, ADDR, WDATA and WSTRB. Go to AR (read) or AWW (write).
//    No request pending -> stay in IDLE.
//  - AR: M_ARVALID=1 with the latched address. On ARREADY -> R.
//  - R: M_RREADY=1. On RVALID, latch RDATA and ERR = RRESP[1] -> RSP.
//  - AWW: M_AWVALID and M_WVALID both assert on entry. Each deasserts independently on its
//    own handshake, so either order or the same cycle is legal. When both are done -> B.
//  - B: M_BREADY=1. On BVALID, ERR = BRESP[1] and RDATA = 0 -> RSP.
//  - RSP: REQ_DONE[grant]=1 for exactly one cycle. Pointer <= (grant+1) mod N_REQ -> IDLE.
//  - The granted REQ_VALID is ignored in RSP. If it is still high in the following IDLE
//    cycle, it is a new request and arbitrates normally.
//  - Minimum latency with a zero-wait slave: read = 4 cycles and write = 4 cycles, counted
//    from the IDLE sample edge to REQ_DONE.
//  - Address, data and strobe on M_* are registered and stay stable while VALID is high
//    (AXI rule). Requester inputs may change after latching without effect.
//  - Requester deasserting REQ_VALID before DONE is illegal. The transaction still
//    completes and DONE still pulses.
//  - Reset mid-transaction aborts immediately; the slave must be reset together with it.
// CONFIGURATION
//  ARB_RANGE_CHECK_EN defined:
//    - In IDLE, a granted request with ADDR >= INT_MEM_SIZE goes straight to RSP with
//      REQ_ERR=1 and REQ_RDATA=0.
//    - No M_* channel activity occurs for that request.
//    - The pointer advances as for a normal completion.
//  ARB_RANGE_CHECK_EN undefined: every request is forwarded; address decoding is the slave's job.
// TESTING
//  1 Reset: NRST low 2 cycles, no requests -> all outputs 0. First grant after reset goes to
//    requester 0.
//  2 Read: REQ1 read 0x100; slave ARREADY=1, RVALID next cycle with RDATA=0xDEADBEEF, OKAY
//    -> M_ARADDR=0x100, one pulse REQ_DONE=2'b10, RDATA=0xDEADBEEF, ERR=0, 4 cycles after sample.
//  3 Contention: REQ0 and REQ1 both held high continuously -> grant order 0,1,0,1.
//    No back-to-back grants to the same requester.
//  4 Write: REQ0 write 0x40, data 0xA5A5A5A5, strobe 0xF; AWREADY delayed 3 cycles, WREADY
//    immediate -> WVALID high 1 cycle, AWVALID high 4 cycles, M_AWADDR stable.
//    BRESP=2'b10 -> REQ_ERR=1 on DONE.
//  5 Reset mid-read: drop NRST while in R -> M_ARVALID, M_RREADY and REQ_DONE go 0 with no
//    clock edge. After release, a fresh REQ1 is serviced normally.
//  6 Range: read 0x80000 -> macro defined: DONE+ERR 1 cycle after sample, M_ARVALID never
//    asserts. Macro undefined: M_ARADDR=0x80000 is issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one AXI4-Lite master port among N_REQ requesters
// Optional ARB_RANGE_CHECK_EN: out-of-range addresses complete locally with REQ_ERR and no bus activity.
module mem_port_arbiter #(
  parameter int N_REQ        = 2,
  parameter int AXI_AWIDTH   = 32,
  parameter int AXI_DWIDTH   = 32,
  parameter int INT_MEM_SIZE = 65536*8
) (
  input  logic                            CLK,
  input  logic                            NRST,
  input  logic [N_REQ-1:0]                REQ_VALID,
  input  logic [N_REQ-1:0]                REQ_WE,
  input  logic [N_REQ*AXI_AWIDTH-1:0]     REQ_ADDR,
  input  logic [N_REQ*AXI_DWIDTH-1:0]     REQ_WDATA,
  input  logic [N_REQ*AXI_DWIDTH/8-1:0]   REQ_WSTRB,
  output logic [N_REQ-1:0]                REQ_DONE,
  output logic [AXI_DWIDTH-1:0]           REQ_RDATA,
  output logic                            REQ_ERR,
  output logic [AXI_AWIDTH-1:0]           M_AWADDR,
  output logic                            M_AWVALID,
  input  logic                            M_AWREADY,
  output logic [AXI_DWIDTH-1:0]           M_WDATA,
  output logic [AXI_DWIDTH/8-1:0]         M_WSTRB,
  output logic                            M_WVALID,
  input  logic                            M_WREADY,
  input  logic [1:0]                      M_BRESP,
  input  logic                            M_BVALID,
  output logic                            M_BREADY,
  output logic [AXI_AWIDTH-1:0]           M_ARADDR,
  output logic                            M_ARVALID,
  input  logic                            M_ARREADY,
  input  logic [AXI_DWIDTH-1:0]           M_RDATA,
  input  logic [1:0]                      M_RRESP,
  input  logic                            M_RVALID,
  output logic                            M_RREADY
);
  localparam int PW  = $clog2(N_REQ);
  localparam int PW1 = PW + 1;
  localparam int SW  = AXI_DWIDTH / 8;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_RSP} state_t;

  state_t                  r_state, w_next;
  logic [PW-1:0]           r_ptr, r_grant;
  logic [AXI_AWIDTH-1:0]   r_addr;
  logic [AXI_DWIDTH-1:0]   r_wdata, r_rdata;
  logic [SW-1:0]           r_wstrb;
  logic                    r_err, r_awvalid, r_wvalid;

  logic [2*N_REQ-1:0]      w_valid_dbl;
  logic [N_REQ-1:0]        w_valid_rot;
  logic [PW1-1:0]          w_off, w_sum;
  logic [PW-1:0]           w_gnt_idx;
  logic                    w_found, w_sel_we, w_out_of_range, w_reject, w_aw_done, w_w_done;
  logic [AXI_AWIDTH-1:0]   w_sel_addr;
  logic [AXI_DWIDTH-1:0]   w_sel_wdata;
  logic [SW-1:0]           w_sel_wstrb;
  logic                    w_unused;

  // Rotate the request vector so bit 0 is the pointer position, then take the lowest set bit.
  assign w_valid_dbl = {REQ_VALID, REQ_VALID};
  assign w_valid_rot = w_valid_dbl[r_ptr +: N_REQ];

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_valid_rot[i]) begin
        w_found = 1'b1;
        w_off   = PW1'(i);
      end
    end
  end

  assign w_sum       = {1'b0, r_ptr} + w_off;
  assign w_gnt_idx   = (w_sum >= PW1'(N_REQ)) ? PW'(w_sum - PW1'(N_REQ)) : PW'(w_sum);
  assign w_sel_we    = REQ_WE[w_gnt_idx];
  assign w_sel_addr  = REQ_ADDR[w_gnt_idx*AXI_AWIDTH +: AXI_AWIDTH];
  assign w_sel_wdata = REQ_WDATA[w_gnt_idx*AXI_DWIDTH +: AXI_DWIDTH];
  assign w_sel_wstrb = REQ_WSTRB[w_gnt_idx*SW +: SW];
  assign w_out_of_range = (64'(w_sel_addr) >= 64'(INT_MEM_SIZE));

`ifdef ARB_RANGE_CHECK_EN
  assign w_reject = w_out_of_range;
  assign w_unused = ^{M_RRESP[0], M_BRESP[0]};
`else
  assign w_reject = 1'b0;
  assign w_unused = ^{M_RRESP[0], M_BRESP[0], w_out_of_range};
`endif

  assign w_aw_done = !r_awvalid || M_AWREADY;
  assign w_w_done  = !r_wvalid  || M_WREADY;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    REQ_DONE  = '0;
    M_ARVALID = 1'b0;
    M_RREADY  = 1'b0;
    M_BREADY  = 1'b0;
    case (r_state)
      S_IDLE: if (w_found) w_next = w_reject ? S_RSP : (w_sel_we ? S_AWW : S_AR);
      S_AR: begin
        M_ARVALID = 1'b1;
        if (M_ARREADY) w_next = S_R;
      end
      S_R: begin
        M_RREADY = 1'b1;
        if (M_RVALID) w_next = S_RSP;
      end
      S_AWW: if (w_aw_done && w_w_done) w_next = S_B;
      S_B: begin
        M_BREADY = 1'b1;
        if (M_BVALID) w_next = S_RSP;
      end
      S_RSP: begin
        REQ_DONE[r_grant] = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_ptr     <= '0;
      r_grant   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          r_grant   <= w_gnt_idx;
          r_addr    <= w_sel_addr;
          r_wdata   <= w_sel_wdata;
          r_wstrb   <= w_sel_wstrb;
          r_rdata   <= '0;
          r_err     <= w_reject;
          r_awvalid <= w_sel_we && !w_reject;
          r_wvalid  <= w_sel_we && !w_reject;
        end
        S_R: if (M_RVALID) begin
          r_rdata <= M_RDATA;
          r_err   <= M_RRESP[1];
        end
        S_AWW: begin
          if (M_AWREADY) r_awvalid <= 1'b0;
          if (M_WREADY)  r_wvalid  <= 1'b0;
        end
        S_B: if (M_BVALID) begin
          r_rdata <= '0;
          r_err   <= M_BRESP[1];
        end
        S_RSP: r_ptr <= (r_grant == PW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
        default: ;
      endcase
    end
  end

  assign M_AWADDR  = r_addr;
  assign M_ARADDR  = r_addr;
  assign M_WDATA   = r_wdata;
  assign M_WSTRB   = r_wstrb;
  assign M_AWVALID = r_awvalid;
  assign M_WVALID  = r_wvalid;
  assign REQ_RDATA = r_rdata;
  assign REQ_ERR   = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a reactive AXI4-Lite slave
// Range-check expectations follow ARB_RANGE_CHECK_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int N = 2, AW = 32, DW = 32;

  logic          CLK = 1'b0, NRST = 1'b1;
  logic [N-1:0]  REQ_VALID = '0, REQ_WE = '0;
  logic [N*AW-1:0] REQ_ADDR = '0;
  logic [N*DW-1:0] REQ_WDATA = '0;
  logic [N*DW/8-1:0] REQ_WSTRB = '0;
  logic [N-1:0]  REQ_DONE;
  logic [DW-1:0] REQ_RDATA;
  logic          REQ_ERR;
  logic [AW-1:0] M_AWADDR, M_ARADDR;
  logic          M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
  logic [DW-1:0] M_WDATA;
  logic [DW/8-1:0] M_WSTRB;
  logic          M_AWREADY, M_WREADY, M_BVALID, M_ARREADY, M_RVALID;
  logic [1:0]    M_BRESP, M_RRESP;
  logic [DW-1:0] M_RDATA;

  mem_port_arbiter #(.N_REQ(N), .AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .INT_MEM_SIZE(65536*8)) dut (
    .CLK(CLK), .NRST(NRST), .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB), .REQ_DONE(REQ_DONE), .REQ_RDATA(REQ_RDATA),
    .REQ_ERR(REQ_ERR), .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_ARADDR(M_ARADDR),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY));

  always #5 CLK = ~CLK;

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // slave knobs
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0]    s_rresp = 2'b00, s_bresp = 2'b00;

  initial begin
    int ar_n, r_n, aw_n, w_n;
    ar_n = 0; r_n = 0; aw_n = 0; w_n = 0;
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 0;
    M_ARREADY = 0; M_RVALID = 0; M_RDATA = 0; M_RRESP = 0;
    forever begin
      @(negedge CLK);
      if (!NRST) begin
        ar_n = 0; r_n = 0; aw_n = 0; w_n = 0;
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_ARREADY = 0; M_RVALID = 0;
      end else begin
        M_ARREADY = M_ARVALID && (ar_n == ar_dly);
        ar_n      = M_ARVALID ? ar_n + 1 : 0;
        M_AWREADY = M_AWVALID && (aw_n == aw_dly);
        aw_n      = M_AWVALID ? aw_n + 1 : 0;
        M_WREADY  = M_WVALID && (w_n == w_dly);
        w_n       = M_WVALID ? w_n + 1 : 0;
        M_RVALID  = M_RREADY && (r_n == r_dly);
        M_RDATA   = M_RVALID ? s_rdata : '0;
        M_RRESP   = M_RVALID ? s_rresp : 2'b00;
        r_n       = M_RREADY ? r_n + 1 : 0;
        M_BVALID  = M_BREADY;
        M_BRESP   = M_BREADY ? s_bresp : 2'b00;
      end
    end
  end

  // bus monitor
  int awv_n = 0, wv_n = 0, arv_n = 0, aw_bad = 0;
  logic [AW-1:0] first_awaddr = '0, last_araddr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [DW/8-1:0] last_wstrb = '0;

  initial forever begin
    @(negedge CLK);
    if (M_AWVALID) begin
      if (awv_n == 0) first_awaddr = M_AWADDR;
      else if (M_AWADDR !== first_awaddr) aw_bad++;
      awv_n++;
    end
    if (M_WVALID) begin
      wv_n++;
      last_wdata = M_WDATA;
      last_wstrb = M_WSTRB;
    end
    if (M_ARVALID) begin
      arv_n++;
      last_araddr = M_ARADDR;
    end
  end

  task automatic clr_mon();
    awv_n = 0; wv_n = 0; arv_n = 0; aw_bad = 0;
  endtask

  typedef struct {
    logic [N-1:0]  done;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input int idx, input logic [DW-1:0] rd, input logic er);
    exp_t e;
    e.done  = N'(1) << idx;
    e.rdata = rd;
    e.err   = er;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int start, output int lat);
    exp_t e;
    bit   seen;
    seen = 0;
    lat  = start;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge CLK);
      lat++;
      if (REQ_DONE != '0) seen = 1;
    end
    if (!seen) begin
      check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    end else if (sb.size() == 0) begin
      check_eq({tag, "_unexpected_done"}, 64'(REQ_DONE), 64'd0);
    end else begin
      e = sb.pop_front();
      check_eq({tag, "_done"}, 64'(REQ_DONE), 64'(e.done));
      check_eq({tag, "_rdata"}, 64'(REQ_RDATA), 64'(e.rdata));
      check_eq({tag, "_err"}, 64'(REQ_ERR), 64'(e.err));
    end
  endtask

  // Caller is at a negedge with the DUT idle; latency counts the sampling IDLE cycle as 1.
  task automatic do_req(input string tag, input int idx, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [3:0] st,
                        input logic [DW-1:0] erd, input logic eerr, input int elat);
    int lat;
    REQ_WE[idx]              = we;
    REQ_ADDR[idx*AW +: AW]   = addr;
    REQ_WDATA[idx*DW +: DW]  = wd;
    REQ_WSTRB[idx*4 +: 4]    = st;
    REQ_VALID[idx]           = 1'b1;
    push_exp(idx, erd, eerr);
    wait_done(tag, 1, lat);
    REQ_VALID[idx] = 1'b0;
    check_eq({tag, "_lat"}, 64'(lat), 64'(elat));
    @(negedge CLK);
    check_eq({tag, "_pulse"}, 64'(REQ_DONE), 64'd0);
  endtask

  initial begin
    int lat;
    #1 NRST = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("rst_ctrl", 64'({M_ARVALID, M_AWVALID, M_WVALID, M_BREADY, M_RREADY, REQ_DONE, REQ_ERR}), 64'd0);
    check_eq("rst_rdata", 64'(REQ_RDATA), 64'd0);
    check_eq("rst_addr", {M_AWADDR, M_ARADDR}, 64'd0);
    check_eq("rst_wdata", 64'({M_WDATA, M_WSTRB}), 64'd0);
    NRST = 1'b1;
    @(negedge CLK);

    // contention: both held, first grant to requester 0, then strict alternation
    clr_mon();
    s_rdata = 32'h1111_2222;
    REQ_WE = '0;
    REQ_ADDR = {32'h20, 32'h10};
    for (int k = 0; k < 4; k++) push_exp(k % 2, 32'h1111_2222, 1'b0);
    REQ_VALID = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done("rr", 1, lat);
      if (k == 3) REQ_VALID = 2'b00;
    end
    @(negedge CLK);
    check_eq("rr_ar_count", 64'(arv_n), 64'd4);

    // REQ1 zero-wait read
    clr_mon();
    s_rdata = 32'hDEAD_BEEF;
    do_req("rd1", 1, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 4);
    check_eq("rd1_araddr", 64'(last_araddr), 64'h100);
    check_eq("rd1_ar_count", 64'(arv_n), 64'd1);

    // read with SLVERR
    s_rdata = 32'h0BAD_0BAD;
    s_rresp = 2'b10;
    do_req("rderr", 0, 1'b0, 32'h200, 32'h0, 4'h0, 32'h0BAD_0BAD, 1'b1, 4);
    s_rresp = 2'b00;

    // write with AWREADY delayed 3, WREADY immediate, BRESP SLVERR; inputs scrambled after latch
    clr_mon();
    aw_dly = 3; w_dly = 0; s_bresp = 2'b10;
    REQ_WE[0] = 1'b1; REQ_ADDR[31:0] = 32'h40; REQ_WDATA[31:0] = 32'hA5A5_A5A5; REQ_WSTRB[3:0] = 4'hF;
    REQ_VALID[0] = 1'b1;
    push_exp(0, 32'h0, 1'b1);
    @(negedge CLK);
    REQ_ADDR[31:0] = 32'hFFFF_0000; REQ_WDATA[31:0] = 32'h1234_5678; REQ_WSTRB[3:0] = 4'h1;
    wait_done("wr", 2, lat);
    REQ_VALID[0] = 1'b0;
    check_eq("wr_lat", 64'(lat), 64'd7);
    check_eq("wr_awvalid_cycles", 64'(awv_n), 64'd4);
    check_eq("wr_wvalid_cycles", 64'(wv_n), 64'd1);
    check_eq("wr_awaddr", 64'(first_awaddr), 64'h40);
    check_eq("wr_awaddr_stable", 64'(aw_bad), 64'd0);
    check_eq("wr_wdata", 64'({last_wdata, last_wstrb}), {28'h0, 32'hA5A5_A5A5, 4'hF});
    @(negedge CLK);

    // write with W delayed, AW immediate, OKAY
    clr_mon();
    aw_dly = 0; w_dly = 2; s_bresp = 2'b00;
    do_req("wr2", 1, 1'b1, 32'h80, 32'h0102_0304, 4'h3, 32'h0, 1'b0, 6);
    check_eq("wr2_awvalid_cycles", 64'(awv_n), 64'd1);
    check_eq("wr2_wvalid_cycles", 64'(wv_n), 64'd3);

    // zero-wait write
    w_dly = 0;
    do_req("wr3", 0, 1'b1, 32'hC0, 32'h5555_AAAA, 4'hF, 32'h0, 1'b0, 4);

    // reset during R
    r_dly = 20;
    REQ_WE[1] = 1'b0; REQ_ADDR[63:32] = 32'h300; REQ_VALID[1] = 1'b1;
    begin
      bit in_r;
      in_r = 0;
      for (int c = 0; c < 20 && !in_r; c++) begin
        @(negedge CLK);
        if (M_RREADY) in_r = 1;
      end
      check_eq("rstmid_reach_r", 64'(in_r), 64'd1);
    end
    #2 NRST = 1'b0;
    #1 check_eq("rstmid_async", 64'({M_ARVALID, M_RREADY, REQ_DONE}), 64'd0);
    REQ_VALID = '0;
    sb.delete();
    repeat (2) @(negedge CLK);
    NRST = 1'b1;
    r_dly = 0;
    @(negedge CLK);
    s_rdata = 32'hCAFE_F00D;
    do_req("rstmid_after", 1, 1'b0, 32'h304, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 4);

    // range boundary: last word in range, then first address past the end
    s_rdata = 32'h7777_0000;
    do_req("rng_in", 0, 1'b0, 32'h7FFFC, 32'h0, 4'h0, 32'h7777_0000, 1'b0, 4);
    clr_mon();
    s_rdata = 32'h8888_0000;
`ifdef ARB_RANGE_CHECK_EN
    do_req("rng_out", 1, 1'b0, 32'h80000, 32'h0, 4'h0, 32'h0, 1'b1, 2);
    check_eq("rng_out_no_ar", 64'(arv_n), 64'd0);
    do_req("rng_next", 0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h8888_0000, 1'b0, 4);
`else
    do_req("rng_out", 1, 1'b0, 32'h80000, 32'h0, 4'h0, 32'h8888_0000, 1'b0, 4);
    check_eq("rng_out_araddr", 64'(last_araddr), 64'h80000);
`endif

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
